mio_uart_tx: RTL and testbench

// - Memory-mapped UART transmitter that sits behind MIO_BUS as a bus responder.
// - The SCPU writes bytes into an internal FIFO; the block serialises them 8N1 (LSB first) on tx.
// - Status and divisor registers are read back over the same word port.
// - Gives the CPU a serial output path in addition to the LED, SPIO and 7-seg outputs.

---
 rtl/mio_uart_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_mio_uart_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, status and divisor registers.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mio_uart_tx #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            irq_q, irq_d;
    logic            pop;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [3:0]      count_q;
    logic            ovf_q;
    logic [15:0]     div_q;

    logic            full, empty, push, push_ok, bit_end;
    logic [7:0]      head;
    logic [15:0]     div_m1;
    logic            unused_wdata;

`ifdef UART_PARITY_EN
    logic            par_q, par_d;
`endif

    assign full    = (count_q == 4'(FIFO_DEPTH));
    assign empty   = (count_q == 4'd0);
    assign push    = we_i && (addr_i == 2'd0);
    assign push_ok = push && !full;
    assign head    = mem_q[rd_ptr_q];
    assign bit_end = (baud_q == 16'd0);
    assign div_m1  = div_q - 16'd1;

    assign unused_wdata = ^wdata_i[31:16];

    // FIFO storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
            ovf_q    <= 1'b0;
            div_q    <= 16'(BAUD_DIV);
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
            // A full FIFO drops the byte even if the FSM pops in the same cycle.
            if (push && full) begin
                ovf_q <= 1'b1;
            end else if (we_i && (addr_i == 2'd1) && wdata_i[7]) begin
                ovf_q <= 1'b0;
            end
            if (we_i && (addr_i == 2'd2)) begin
                div_q <= (wdata_i[15:0] < 16'd2) ? 16'd2 : wdata_i[15:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // The baud counter is reloaded from div_q only at bit start, so divisor
    // writes never stretch or shorten the bit in progress.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        irq_d   = 1'b0;
        pop     = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    baud_d  = div_m1;
`ifdef UART_PARITY_EN
                    par_d   = ^head;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    baud_d  = div_m1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = div_m1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    baud_d  = div_m1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = S_START;
                        tx_d    = 1'b0;
                        baud_d  = div_m1;
`ifdef UART_PARITY_EN
                        par_d   = ^head;
`endif
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        irq_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        rdata_o = 32'd0;
        case (addr_i)
            2'd1:    rdata_o = {24'd0, ovf_q, (state_q != S_IDLE), full, empty, count_q};
            2'd2:    rdata_o = {16'd0, div_q};
            default: rdata_o = 32'd0;
        endcase
    end

    assign tx_o  = tx_q;
    assign irq_o = irq_q;

endmodule

// File: tb/tb_mio_uart_tx.sv
// Directed bench for mio_uart_tx: register vectors from a table, plus frame,
// back-to-back, overflow, divisor-change and mid-frame reset sequences.
module tb_mio_uart_tx;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  addr_i = 2'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] rdata_o;
    logic        tx_o;
    logic        irq_o;

    int checks = 0;
    int failures = 0;
    logic [7:0] byte_q [$];

    always #5 clk_i = ~clk_i;

    mio_uart_tx #(.BAUD_DIV(868), .FIFO_DEPTH(8)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .tx_o    (tx_o),
        .irq_o   (irq_o)
    );

    typedef struct {
        logic        do_wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr_i  = a;
        wdata_i = d;
        we_i    = 1'b1;
        tick();
        we_i    = 1'b0;
        wdata_i = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr_i = a;
        #1;
        d = rdata_o;
    endtask

    function automatic logic exp_tx(input int div, input int k);
        int f;
        int b;
        logic [7:0] d;
        f = k / (10 * div);
        b = (k % (10 * div)) / div;
        d = byte_q[f];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    // Pushes byte_q on consecutive cycles, then checks every cycle of the
    // resulting contiguous frames and the single irq pulse at the end.
    task automatic send_frames(input int div);
        int n;
        int total;
        n = byte_q.size();
        total = 10 * div * n;
        for (int i = 0; i < n; i++) begin
            addr_i  = 2'd0;
            wdata_i = {24'd0, byte_q[i]};
            we_i    = 1'b1;
            tick();
            if (i == 0) chk("tx_idle_at_push_edge", {31'd0, tx_o}, 32'd1);
            else chk($sformatf("tx_k%0d", i - 1), {31'd0, tx_o}, {31'd0, exp_tx(div, i - 1)});
        end
        we_i    = 1'b0;
        wdata_i = 32'd0;
        addr_i  = 2'd1;
        for (int k = n - 1; k < total; k++) begin
            tick();
            chk($sformatf("tx_k%0d", k), {31'd0, tx_o}, {31'd0, exp_tx(div, k)});
            chk($sformatf("irq_quiet_k%0d", k), {31'd0, irq_o}, 32'd0);
            chk($sformatf("busy_k%0d", k), {31'd0, rdata_o[6]}, 32'd1);
        end
        tick();
        chk("irq_pulse", {31'd0, irq_o}, 32'd1);
        chk("tx_idle_after", {31'd0, tx_o}, 32'd1);
        chk("busy_clear_after", {31'd0, rdata_o[6]}, 32'd0);
        tick();
        chk("irq_one_cycle", {31'd0, irq_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;

        vecs[0] = '{1'b0, 2'd0, 32'h0000_0000, 2'd1, 32'h0000_0010};
        vecs[1] = '{1'b0, 2'd0, 32'h0000_0000, 2'd2, 32'd868};
        vecs[2] = '{1'b1, 2'd2, 32'h0000_0000, 2'd2, 32'd2};
        vecs[3] = '{1'b1, 2'd2, 32'h0000_0001, 2'd2, 32'd2};
        vecs[4] = '{1'b1, 2'd2, 32'h0000_0003, 2'd2, 32'd3};
        vecs[5] = '{1'b1, 2'd2, 32'h0001_2345, 2'd2, 32'h0000_2345};
        vecs[6] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
        vecs[7] = '{1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
        vecs[8] = '{1'b1, 2'd1, 32'h0000_0080, 2'd1, 32'h0000_0010};
        vecs[9] = '{1'b0, 2'd0, 32'h0000_0000, 2'd2, 32'h0000_2345};

        // Reset held for several edges: line idle, no irq, status empty.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_tx", {31'd0, tx_o}, 32'd1);
            chk("reset_irq", {31'd0, irq_o}, 32'd0);
        end
        rd(2'd1, r);
        chk("reset_status", r, 32'h10);
        rstn_i = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, r);
            chk($sformatf("reg_vec%0d", i), r, vecs[i].exp);
            chk($sformatf("reg_vec%0d_tx", i), {31'd0, tx_o}, 32'd1);
        end

        // Divisor change mid start bit, then reset during a data bit.
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h01);
        chk("mid_tx_at_push", {31'd0, tx_o}, 32'd1);
        tick();
        chk("mid_start_c0", {31'd0, tx_o}, 32'd0);
        tick();
        chk("mid_start_c1", {31'd0, tx_o}, 32'd0);
        wr(2'd2, 32'd8);
        chk("mid_start_c2", {31'd0, tx_o}, 32'd0);
        tick();
        chk("mid_start_c3", {31'd0, tx_o}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("mid_bit0_c%0d", i), {31'd0, tx_o}, 32'd1);
        end
        tick();
        chk("mid_bit1_first", {31'd0, tx_o}, 32'd0);
        rstn_i = 1'b0;
        tick();
        chk("abort_tx", {31'd0, tx_o}, 32'd1);
        chk("abort_irq", {31'd0, irq_o}, 32'd0);
        rd(2'd1, r);
        chk("abort_status", r, 32'h10);
        rd(2'd2, r);
        chk("abort_div", r, 32'd868);
        rstn_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_abort_irq", {31'd0, irq_o}, 32'd0);
            chk("post_abort_tx", {31'd0, tx_o}, 32'd1);
        end

        // Single frame 0x55 at div 4.
        wr(2'd2, 32'd4);
        byte_q = {8'h55};
        send_frames(4);

        // Three back-to-back frames at div 2.
        wr(2'd2, 32'd2);
        byte_q = {8'hA1, 8'hB2, 8'hC3};
        send_frames(2);

        // Overflow: one byte popped immediately, eight accepted, tenth dropped.
        wr(2'd2, 32'd1000);
        for (int i = 0; i < 10; i++) wr(2'd0, 32'h30 + i);
        rd(2'd1, r);
        chk("ovf_status", r, 32'h0000_00E8);
        chk("ovf_tx_start", {31'd0, tx_o}, 32'd0);
        wr(2'd1, 32'h80);
        rd(2'd1, r);
        chk("ovf_cleared", r, 32'h0000_0068);
        rstn_i = 1'b0;
        tick();
        tick();
        chk("final_reset_tx", {31'd0, tx_o}, 32'd1);
        rstn_i = 1'b1;
        rd(2'd1, r);
        chk("final_status", r, 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
